// File: rtl/wb_pkg.sv
// Shared constants and helpers for the writeback arbiter and its source FIFOs.
package wb_pkg;

  localparam int unsigned DATA_W  = 40;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned NUM_REG = 32;

  localparam logic [4:0] R_DISCARD = 5'd31;

  localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] SRC_MEM = 2'd1;
  localparam logic [SRC_W-1:0] SRC_MUL = 2'd2;

  // Reduce a small sum (0 .. 2*NUM_SRC-1) back into a source index.
  function automatic logic [SRC_W-1:0] src_wrap(input logic [SRC_W:0] v);
    if (v >= (SRC_W+1)'(NUM_SRC)) begin
      return SRC_W'(v - (SRC_W+1)'(NUM_SRC));
    end
    return SRC_W'(v);
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source {addr, data} result FIFO; exposes head, full/empty and per-entry
// valid/address so the top level can build the pending-write vector.
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ENT_DATA_W = 40,
  parameter int unsigned ENT_ADDR_W = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_push,
  input  logic [ENT_ADDR_W-1:0]                i_addr,
  input  logic [ENT_DATA_W-1:0]                i_data,
  input  logic                                 i_pop,
  output logic [ENT_ADDR_W-1:0]                o_head_addr,
  output logic [ENT_DATA_W-1:0]                o_head_data,
  output logic                                 o_empty,
  output logic                                 o_full,
  output logic [DEPTH-1:0]                     o_ent_vld,
  output logic [DEPTH-1:0][ENT_ADDR_W-1:0]     o_ent_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0]          r_wr_ptr;
  logic [PTR_W:0]          r_rd_ptr;
  logic [PTR_W:0]          w_count;
  logic                    w_do_push;
  logic                    w_do_pop;
  logic [ENT_ADDR_W-1:0]   r_addr [DEPTH];
  logic [ENT_DATA_W-1:0]   r_data [DEPTH];

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (w_count == '0);
  assign o_full    = (w_count == (PTR_W+1)'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr[r_wr_ptr[PTR_W-1:0]] <= i_addr;
      r_data[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  assign o_head_addr = r_addr[r_rd_ptr[PTR_W-1:0]];
  assign o_head_data = r_data[r_rd_ptr[PTR_W-1:0]];

  // Slot i is live when its distance from the read index is below occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PTR_W-1:0] w_off;
    assign w_off         = PTR_W'(gi) - r_rd_ptr[PTR_W-1:0];
    assign o_ent_vld[gi]  = ({1'b0, w_off} < w_count);
    assign o_ent_addr[gi] = r_addr[gi];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU/MEM/MUL results and issues up to two
// distinct-register writes per cycle with round-robin fairness.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_pkg::ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                srcValid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]    srcAddr,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    srcData,
  output logic [NUM_SRC-1:0]                srcReady,
  output logic [ADDR_W-1:0]                 addrWr0,
  output logic [ADDR_W-1:0]                 addrWr1,
  output logic [DATA_W-1:0]                 dataInWr0,
  output logic [DATA_W-1:0]                 dataInWr1,
  output logic                              writeEn0,
  output logic                              writeEn1,
  output logic [NUM_REG-1:0]                pendingWr,
  output logic [DROP_W-1:0]                 dropCnt
);

  localparam logic [ADDR_W-1:0] DISCARD_ADDR = ADDR_W'(R_DISCARD);
  localparam int unsigned       SUM_W        = DROP_W + 1;

  logic [SRC_W-1:0]                 r_rr;
  logic [SRC_W-1:0]                 w_rr_nxt;
  logic [DROP_W-1:0]                r_drop;
  logic [DROP_W-1:0]                w_drop_nxt;
  logic [SUM_W-1:0]                 w_drop_sum;
  logic [NUM_SRC-1:0]               w_empty;
  logic [NUM_SRC-1:0]               w_full;
  logic [NUM_SRC-1:0]               w_accept;
  logic [NUM_SRC-1:0]               w_drop;
  logic [NUM_SRC-1:0]               w_push;
  logic [NUM_SRC-1:0]               w_pop;
  logic [NUM_SRC-1:0][ADDR_W-1:0]   w_head_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0]   w_head_data;
  logic [DEPTH-1:0]                 w_ent_vld  [NUM_SRC];
  logic [DEPTH-1:0][ADDR_W-1:0]     w_ent_addr [NUM_SRC];
  logic [SRC_W-1:0]                 w_order    [NUM_SRC];
  logic                             w_have0;
  logic                             w_have1;
  logic [SRC_W-1:0]                 w_sel0;
  logic [SRC_W-1:0]                 w_sel1;
  logic [SRC_W-1:0]                 w_last;
  logic [NUM_REG-1:0]               w_pend;

  // Readiness depends on occupancy only, never on the producer's valid.
  assign srcReady = ~w_full;
  assign w_accept = srcValid & srcReady;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_drop[g]  = w_accept[g] && (srcAddr[g] == DISCARD_ADDR);
    assign w_push[g]  = w_accept[g] && (srcAddr[g] != DISCARD_ADDR);
    assign w_order[g] = src_wrap({1'b0, r_rr} + (SRC_W+1)'(g));

    wb_src_fifo #(
      .DEPTH      (DEPTH),
      .ENT_DATA_W (DATA_W),
      .ENT_ADDR_W (ADDR_W)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst),
      .i_push      (w_push[g]),
      .i_addr      (srcAddr[g]),
      .i_data      (srcData[g]),
      .i_pop       (w_pop[g]),
      .o_head_addr (w_head_addr[g]),
      .o_head_data (w_head_data[g]),
      .o_empty     (w_empty[g]),
      .o_full      (w_full[g]),
      .o_ent_vld   (w_ent_vld[g]),
      .o_ent_addr  (w_ent_addr[g])
    );
  end

  // Walk rr, rr+1, rr+2; second pick must target a different register.
  always_comb begin
    w_have0 = 1'b0;
    w_have1 = 1'b0;
    w_sel0  = '0;
    w_sel1  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_empty[w_order[k]]) begin
        if (!w_have0) begin
          w_have0 = 1'b1;
          w_sel0  = w_order[k];
        end else if (!w_have1 && (w_head_addr[w_order[k]] != w_head_addr[w_sel0])) begin
          w_have1 = 1'b1;
          w_sel1  = w_order[k];
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_have0) w_pop[w_sel0] = 1'b1;
    if (w_have1) w_pop[w_sel1] = 1'b1;
  end

  assign w_last   = w_have1 ? w_sel1 : w_sel0;
  assign w_rr_nxt = w_have0 ? src_wrap({1'b0, w_last} + (SRC_W+1)'(1)) : r_rr;

  assign writeEn0  = w_have0;
  assign writeEn1  = w_have1;
  assign addrWr0   = w_have0 ? w_head_addr[w_sel0] : '0;
  assign addrWr1   = w_have1 ? w_head_addr[w_sel1] : '0;
  assign dataInWr0 = w_have0 ? w_head_data[w_sel0] : '0;
  assign dataInWr1 = w_have1 ? w_head_data[w_sel1] : '0;

  // Buffered entries only: this cycle's pushes are not yet visible here.
  always_comb begin
    w_pend = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_ent_vld[s][e]) w_pend[w_ent_addr[s][e]] = 1'b1;
      end
    end
  end

  assign pendingWr = w_pend;

  always_comb begin
    w_drop_sum = {1'b0, r_drop};
    for (int s = 0; s < NUM_SRC; s++) begin
      w_drop_sum = w_drop_sum + SUM_W'(w_drop[s]);
    end
    w_drop_nxt = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  assign dropCnt = r_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr   <= SRC_ALU;
      r_drop <= '0;
    end else begin
      r_rr   <= w_rr_nxt;
      r_drop <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed expectations checked with
// immediate assertions at each step.
module tb_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 40;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [2:0]          srcValid;
  logic [2:0][AW-1:0]  srcAddr;
  logic [2:0][DW-1:0]  srcData;
  logic [2:0]          srcReady;
  logic [AW-1:0]       addrWr0, addrWr1;
  logic [DW-1:0]       dataInWr0, dataInWr1;
  logic                writeEn0, writeEn1;
  logic [31:0]         pendingWr;
  logic [7:0]          dropCnt;

  int n_vec  = 0;
  int n_fail = 0;
  int bad    = 0;

  wb_arbiter #(.DEPTH(2), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .srcValid  (srcValid),
    .srcAddr   (srcAddr),
    .srcData   (srcData),
    .srcReady  (srcReady),
    .addrWr0   (addrWr0),
    .addrWr1   (addrWr1),
    .dataInWr0 (dataInWr0),
    .dataInWr1 (dataInWr1),
    .writeEn0  (writeEn0),
    .writeEn1  (writeEn1),
    .pendingWr (pendingWr),
    .dropCnt   (dropCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    srcValid = '0;
    srcAddr  = '0;
    srcData  = '0;
  endtask

  task automatic push(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    srcValid[s] = 1'b1;
    srcAddr[s]  = a;
    srcData[s]  = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic chk_p0(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_we0"},   64'(writeEn0),  64'(en));
    check({tag, "_addr0"}, 64'(addrWr0),   64'(a));
    check({tag, "_data0"}, 64'(dataInWr0), 64'(d));
  endtask

  task automatic chk_p1(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_we1"},   64'(writeEn1),  64'(en));
    check({tag, "_addr1"}, 64'(addrWr1),   64'(a));
    check({tag, "_data1"}, 64'(dataInWr1), 64'(d));
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, "_ready"}, 64'(srcReady),  64'(3'b111));
    check({tag, "_we0"},   64'(writeEn0),  64'(0));
    check({tag, "_we1"},   64'(writeEn1),  64'(0));
    check({tag, "_pend"},  64'(pendingWr), 64'(0));
    check({tag, "_drop"},  64'(dropCnt),   64'(0));
  endtask

  initial begin
    idle();
    #12;
    chk_reset_state("in_reset");
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("idle");

    // Single ALU push to R5.
    push(0, 5'd5, 40'h12_3456_789A);
    tick();
    idle();
    check("single_pend", 64'(pendingWr), 64'(32'h0000_0020));
    chk_p0("single", 1'b1, 5'd5, 40'h12_3456_789A);
    chk_p1("single", 1'b0, 5'd0, 40'h0);
    tick();
    chk_p0("single_done", 1'b0, 5'd0, 40'h0);
    check("single_done_pend", 64'(pendingWr), 64'(0));

    // Three sources to distinct registers, rr = 0.
    do_reset();
    push(0, 5'd1, 40'hA1);
    push(1, 5'd2, 40'hB2);
    push(2, 5'd3, 40'hC3);
    tick();
    idle();
    check("three_pend", 64'(pendingWr), 64'(32'h0000_000E));
    chk_p0("three_c1", 1'b1, 5'd1, 40'hA1);
    chk_p1("three_c1", 1'b1, 5'd2, 40'hB2);
    tick();
    chk_p0("three_c2", 1'b1, 5'd3, 40'hC3);
    chk_p1("three_c2", 1'b0, 5'd0, 40'h0);
    tick();
    check("three_c3_we0", 64'(writeEn0), 64'(0));

    // ALU and MEM both target R7: serialized, port 1 idle.
    do_reset();
    push(0, 5'd7, 40'h77);
    push(1, 5'd7, 40'h88);
    tick();
    idle();
    check("same_pend", 64'(pendingWr), 64'(32'h0000_0080));
    chk_p0("same_c1", 1'b1, 5'd7, 40'h77);
    chk_p1("same_c1", 1'b0, 5'd0, 40'h0);
    tick();
    chk_p0("same_c2", 1'b1, 5'd7, 40'h88);
    chk_p1("same_c2", 1'b0, 5'd0, 40'h0);
    tick();
    check("same_c3_we0", 64'(writeEn0), 64'(0));
    check("same_c3_pend", 64'(pendingWr), 64'(0));

    // MUL fills while its R9 head loses to other R9 writers.
    do_reset();
    push(0, 5'd9, 40'h1);
    push(1, 5'd9, 40'h2);
    push(2, 5'd9, 40'h3);
    tick();
    idle();
    check("full_c1_ready", 64'(srcReady), 64'(3'b111));
    chk_p0("full_c1", 1'b1, 5'd9, 40'h1);
    chk_p1("full_c1", 1'b0, 5'd0, 40'h0);
    push(2, 5'd11, 40'h4);
    tick();
    check("full_c2_ready", 64'(srcReady), 64'(3'b011));
    check("full_c2_pend", 64'(pendingWr), 64'(32'h0000_0A00));
    chk_p0("full_c2", 1'b1, 5'd9, 40'h2);
    push(2, 5'd12, 40'h5);
    tick();
    check("full_c3_ready", 64'(srcReady), 64'(3'b011));
    chk_p0("full_c3", 1'b1, 5'd9, 40'h3);
    tick();
    check("full_c4_ready", 64'(srcReady), 64'(3'b111));
    check("full_c4_pend", 64'(pendingWr), 64'(32'h0000_0800));
    chk_p0("full_c4", 1'b1, 5'd11, 40'h4);
    tick();
    idle();
    chk_p0("full_c5", 1'b1, 5'd12, 40'h5);
    chk_p1("full_c5", 1'b0, 5'd0, 40'h0);
    tick();
    check("full_c6_we0", 64'(writeEn0), 64'(0));

    // 300 writes to R31 are swallowed; counter saturates.
    do_reset();
    push(0, 5'd31, 40'hDEAD);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (writeEn0 || writeEn1 || (pendingWr != 32'h0)) bad++;
      if (i == 99) check("r31_drop100", 64'(dropCnt), 64'(100));
    end
    idle();
    check("r31_no_write", 64'(bad), 64'(0));
    check("r31_drop_sat", 64'(dropCnt), 64'(255));
    check("r31_ready", 64'(srcReady), 64'(3'b111));

    // Fill FIFOs with R4 writes, then assert reset between edges.
    push(0, 5'd4, 40'h10);
    push(1, 5'd4, 40'h20);
    push(2, 5'd4, 40'h30);
    tick();
    push(0, 5'd4, 40'h11);
    push(1, 5'd4, 40'h21);
    push(2, 5'd4, 40'h31);
    tick();
    idle();
    check("pre_rst_ready", 64'(srcReady), 64'(3'b001));
    check("pre_rst_pend", 64'(pendingWr), 64'(32'h0000_0010));
    chk_p0("pre_rst", 1'b1, 5'd4, 40'h20);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    check("async_rst_addr0", 64'(addrWr0), 64'(0));
    #3;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
